// File: rtl/riscv_decode_queue.sv
// riscv_decode_queue: registered RISC-V decode stage feeding a QDEPTH-entry
// FIFO of decoded instructions. Fetch pushes one word per cycle, issue drains
// the head over valid/ready. Adds XLEN/extension gating, illegal-instruction
// flagging, a synchronous flush and a saturating illegal-instruction counter.
module riscv_decode_queue #(
  parameter int XLEN   = 64,
  parameter bit EN_M   = 1'b1,
  parameter bit EN_F   = 1'b1,
  parameter bit EN_D   = 1'b1,
  parameter bit EN_V   = 1'b1,
  parameter bit EN_AI  = 1'b1,
  parameter int QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [XLEN-1:0]             in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_pc,
  output logic [31:0]                 out_instr,
  output logic                        out_reg_write,
  output logic                        out_mem_read,
  output logic                        out_mem_write,
  output logic                        out_branch,
  output logic                        out_jump,
  output logic                        out_alu_src,
  output logic [3:0]                  out_alu_op,
  output logic [1:0]                  out_wb_sel,
  output logic                        out_mdu_en,
  output logic                        out_fpu_en,
  output logic                        out_vec_en,
  output logic                        out_ai_en,
  output logic                        out_is_32bit,
  output logic                        out_is_double,
  output logic                        out_illegal,
  output logic [$clog2(QDEPTH+1)-1:0] count,
  output logic [15:0]                 illegal_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  // Double precision is only usable when single precision is also present.
  localparam bit D_OK = EN_F && EN_D;

  // Major opcodes (bits [6:0] of the instruction word).
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPC_FMADD     = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB     = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD    = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
  localparam logic [6:0] OPC_VECTOR    = 7'b1010111;
  localparam logic [6:0] OPC_AI        = 7'b0001011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MDU  = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,  // memory, vector and AI results
    WB_PC4 = 2'b10,  // link address and FPU results
    WB_MDU = 2'b11
  } wb_sel_e;

  // Control bundle stored with every queued instruction.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    alu_op_e alu_op;
    wb_sel_e wb_sel;
    logic    mdu_en;
    logic    fpu_en;
    logic    vec_en;
    logic    ai_en;
    logic    is_32bit;
    logic    is_double;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctrl_t           ctrl;
  } entry_t;

  // funct3 -> ALU operation; the SUB alternate exists only for register-register ops.
  function automatic alu_op_e f_alu_op(input logic [2:0] funct3, input logic alt, input logic is_reg);
    case (funct3)
      3'b000:  f_alu_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  f_alu_op = ALU_SLL;
      3'b010:  f_alu_op = ALU_SLT;
      3'b011:  f_alu_op = ALU_SLTU;
      3'b100:  f_alu_op = ALU_XOR;
      3'b101:  f_alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f_alu_op = ALU_OR;
      default: f_alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  ctrl_t            w_raw;
  logic             w_bad;
  ctrl_t            w_dec;
  entry_t           w_entry;
  entry_t           w_head;
  entry_t           w_out;
  logic             w_push;
  logic             w_pop;

  entry_t           r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_illegal_cnt;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // Combinational decode of the offered word, then collapse illegal words to a bare flag.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    w_raw = '0;
    w_bad = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_raw.reg_write = 1'b1;
        w_raw.alu_src   = 1'b1;
        w_raw.alu_op    = ALU_LUI;
      end
      OPC_AUIPC: begin
        w_raw.reg_write = 1'b1;
        w_raw.alu_src   = 1'b1;
        w_raw.alu_op    = ALU_AUIPC;
      end
      OPC_JAL, OPC_JALR: begin
        w_raw.reg_write = 1'b1;
        w_raw.jump      = 1'b1;
        w_raw.wb_sel    = WB_PC4;
        w_raw.alu_src   = (w_opcode == OPC_JALR);
      end
      OPC_BRANCH: begin
        w_raw.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_raw.alu_src   = 1'b1;
        w_raw.mem_read  = 1'b1;
        w_raw.reg_write = 1'b1;
        w_raw.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        w_raw.alu_src   = 1'b1;
        w_raw.mem_write = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        if (w_opcode == OPC_OP_IMM_32 && XLEN == 32) w_bad = 1'b1;
        w_raw.reg_write = 1'b1;
        w_raw.alu_src   = 1'b1;
        w_raw.is_32bit  = (w_opcode == OPC_OP_IMM_32);
        w_raw.alu_op    = f_alu_op(w_funct3, w_funct7[5], 1'b0);
      end
      OPC_OP, OPC_OP_32: begin
        if (w_opcode == OPC_OP_32 && XLEN == 32) w_bad = 1'b1;
        w_raw.reg_write = 1'b1;
        w_raw.is_32bit  = (w_opcode == OPC_OP_32);
        if (w_funct7 == F7_MDU) begin
          if (!EN_M) w_bad = 1'b1;
          w_raw.mdu_en = 1'b1;
          w_raw.wb_sel = WB_MDU;
        end else if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
          w_raw.alu_op = f_alu_op(w_funct3, w_funct7[5], 1'b1);
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_LOAD_FP, OPC_STORE_FP: begin
        w_raw.fpu_en    = 1'b1;
        w_raw.wb_sel    = WB_PC4;
        w_raw.is_double = (w_funct3 == 3'b011);
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        w_raw.fpu_en    = 1'b1;
        w_raw.wb_sel    = WB_PC4;
        w_raw.is_double = (in_instr[26:25] == 2'b01);
      end
      OPC_OP_FP: begin
        w_raw.fpu_en    = 1'b1;
        w_raw.wb_sel    = WB_PC4;
        w_raw.is_double = (w_funct7[1:0] == 2'b01);
      end
      OPC_VECTOR: begin
        if (!EN_V) w_bad = 1'b1;
        w_raw.vec_en = 1'b1;
        if (w_funct3 == 3'b111) begin
          w_raw.reg_write = 1'b1;
          w_raw.wb_sel    = WB_MEM;
        end
      end
      OPC_AI: begin
        if (!EN_AI) w_bad = 1'b1;
        w_raw.ai_en     = 1'b1;
        w_raw.reg_write = 1'b1;
        w_raw.wb_sel    = WB_MEM;
      end
      OPC_SYSTEM: begin
        w_raw.reg_write = (w_funct3 != 3'b000);
      end
      OPC_FENCE: begin
        // Ordering only; no datapath control.
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase

    // Extension gating that applies to every floating-point opcode.
    if (w_raw.fpu_en && !EN_F) w_bad = 1'b1;
    if (w_raw.is_double && !D_OK) w_bad = 1'b1;
    // Compressed or reserved encodings are not handled here.
    if (in_instr[1:0] != 2'b11) w_bad = 1'b1;

    w_dec = w_raw;
    if (w_bad) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign w_entry = '{pc: in_pc, instr: in_instr, ctrl: w_dec};

  // Handshake: in_ready depends only on registered occupancy and flush.
  assign out_valid = (r_count != '0);
  assign in_ready  = (r_count != FULL_CNT) && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;

  // Entry storage; written on push, no reset needed.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy tracking and the output gating below keep stale entries invisible.
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // Pointers and occupancy, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of accepted illegal instructions; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_push && w_dec.illegal && r_illegal_cnt != 16'hFFFF) begin
      r_illegal_cnt <= r_illegal_cnt + 16'd1;
    end
  end

  // Head entry, forced to zero while the queue is empty.
  assign w_head = r_mem[r_rd_ptr];
  assign w_out  = out_valid ? w_head : '0;

  assign out_pc        = w_out.pc;
  assign out_instr     = w_out.instr;
  assign out_reg_write = w_out.ctrl.reg_write;
  assign out_mem_read  = w_out.ctrl.mem_read;
  assign out_mem_write = w_out.ctrl.mem_write;
  assign out_branch    = w_out.ctrl.branch;
  assign out_jump      = w_out.ctrl.jump;
  assign out_alu_src   = w_out.ctrl.alu_src;
  assign out_alu_op    = w_out.ctrl.alu_op;
  assign out_wb_sel    = w_out.ctrl.wb_sel;
  assign out_mdu_en    = w_out.ctrl.mdu_en;
  assign out_fpu_en    = w_out.ctrl.fpu_en;
  assign out_vec_en    = w_out.ctrl.vec_en;
  assign out_ai_en     = w_out.ctrl.ai_en;
  assign out_is_32bit  = w_out.ctrl.is_32bit;
  assign out_is_double = w_out.ctrl.is_double;
  assign out_illegal   = w_out.ctrl.illegal;
  assign count         = r_count;
  assign illegal_cnt   = r_illegal_cnt;

endmodule
